mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF) and the
//  MEM stage load/store path (driven from the EX/MEM pipeline register outputs).
//  Fixed priority: MEM over IF, since MEM holds the older instruction.
//  Registers the granted request, runs the memory ack handshake with a timeout,
//  returns read data to the granted requester, and drives a pipeline stall.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    32   data width
//  MAX_WAIT  15   max cycles in a BUSY state without Mem_Ack before error; range 1..255
// PORTS
//  Clk        in   1       clock, rising edge
//  Rst        in   1       asynchronous, active-low reset (0 = reset)
//  IF_Req     in   1       fetch request; held high until IF_Ready
//  IF_Addr    in   ADDR_W  fetch address
//  IF_Ready   out  1       1-cycle pulse: fetch complete
//  IF_RData   out  DATA_W  fetched word; valid while IF_Ready=1
//  MEM_Req    in   1       load/store request; held high until MEM_Ready
//  MEM_We     in   1       1 = store, 0 = load
//  MEM_Addr   in   ADDR_W  load/store address
//  MEM_WData  in   DATA_W  store data
//  MEM_Ready  out  1       1-cycle pulse: load/store complete
//  MEM_RData  out  DATA_W  load data; valid while MEM_Ready=1; 0 for a store
//  Bus_Err    out  1       pulses together with the Ready of a timed-out access
//  Mem_En     out  1       memory access strobe
//  Mem_We     out  1       memory write enable
//  Mem_Addr   out  ADDR_W  memory address
//  Mem_WData  out  DATA_W  memory write data
//  Mem_RData  in   DATA_W  memory read data; valid when Mem_Ack=1
//  Mem_Ack    in   1       memory completion, 1 cycle
//  Pipe_Stall out  1       comb: (IF_Req&~IF_Ready)|(MEM_Req&~MEM_Ready)
// BEHAVIOUR
//  Reset (Rst=0, asynchronous): state=IDLE, wait counter=0.
//   All registered outputs go to 0: Ready/RData/Bus_Err/Mem_* = 0.
//  FSM states: IDLE, BUSY_MEM, BUSY_IF.
//  IDLE:
//   - MEM_Req=1 -> BUSY_MEM, latching MEM_We/Addr/WData.
//   - else IF_Req=1 -> BUSY_IF, latching IF_Addr, with Mem_We=0 and Mem_WData=0.
//   - If both are high in the same cycle, MEM wins and IF waits.
//  BUSY_x: Mem_En=1; Mem_We/Addr/WData come from the latched request only
//   (a change on a requester input mid-access has no effect). Counter increments each cycle.
//  On the clock edge where Mem_Ack=1 in BUSY_x:
//   - Ready_x=1 for exactly one cycle.
//   - RData_x=Mem_RData for a load or fetch, 0 for a store.
//   - Next state IDLE, counter cleared, Mem_* outputs driven to 0 next cycle.
//  Timeout: the edge where the counter reaches MAX_WAIT with Mem_Ack=0 ->
//   Ready_x=1, RData_x=0, Bus_Err=1 (all 1 cycle), then IDLE.
//  Mem_Ack while in IDLE is ignored.
//  Requester drops Req in the cycle after its Ready. A Req still high after Ready
//   starts a new access; a requester must not re-arm in that cycle.
//  Minimum access time: 3 cycles (arbitrate, Mem_En+Ack, Ready).
//  Throughput: 1 access per 3 cycles when Ack returns immediately.
//  Only one access is outstanding at a time; IF and MEM Ready never pulse in the same cycle.
//  Reset mid-access aborts it with no Ready pulse; the memory must tolerate a dropped Mem_En.
// TESTING
//  1 Lone fetch: IF_Req, IF_Addr=0x100, Ack 1 cycle later, Mem_RData=0x8C220004
//     -> Mem_Addr=0x100, Mem_We=0; IF_Ready with IF_RData=0x8C220004; Pipe_Stall high until then.
//  2 Collision: IF_Req and MEM_Req (store, 0x2000, data 0xDEADBEEF) same cycle
//     -> store issued first, then MEM_Ready; fetch is granted only after that Ready.
//  3 Timeout: MEM load with Ack never asserted
//     -> MEM_Ready=1, Bus_Err=1, MEM_RData=0 after MAX_WAIT BUSY cycles (15).
//  4 Input change: MEM_Addr changed 0x40->0x80 mid-access
//     -> Mem_Addr stays 0x40; load completes normally.
//  5 Reset mid-access: Rst=0 in BUSY_IF
//     -> Mem_En=0 immediately, no IF_Ready; after release a new IF_Req is served from IDLE.
//  6 Back-to-back: 4 fetches with Ack immediate
//     -> one IF_Ready every 3 cycles; stray Mem_Ack in IDLE produces no Ready.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the three sides of the shared memory port arbiter:
//   fetch requester   : IF_Req, IF_Addr -> IF_Ready, IF_RData
//   load/store side   : MEM_Req, MEM_We, MEM_Addr, MEM_WData -> MEM_Ready, MEM_RData
//   memory port       : Mem_En, Mem_We, Mem_Addr, Mem_WData -> Mem_RData, Mem_Ack
//   status            : Bus_Err, Pipe_Stall
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (requesters and memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IF_Req;
    logic [ADDR_W-1:0] IF_Addr;
    logic              IF_Ready;
    logic [DATA_W-1:0] IF_RData;

    logic              MEM_Req;
    logic              MEM_We;
    logic [ADDR_W-1:0] MEM_Addr;
    logic [DATA_W-1:0] MEM_WData;
    logic              MEM_Ready;
    logic [DATA_W-1:0] MEM_RData;

    logic              Bus_Err;

    logic              Mem_En;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WData;
    logic [DATA_W-1:0] Mem_RData;
    logic              Mem_Ack;

    logic              Pipe_Stall;

    modport slave (
        input  IF_Req, IF_Addr,
        input  MEM_Req, MEM_We, MEM_Addr, MEM_WData,
        input  Mem_RData, Mem_Ack,
        output IF_Ready, IF_RData,
        output MEM_Ready, MEM_RData,
        output Bus_Err,
        output Mem_En, Mem_We, Mem_Addr, Mem_WData,
        output Pipe_Stall
    );

    modport master (
        output IF_Req, IF_Addr,
        output MEM_Req, MEM_We, MEM_Addr, MEM_WData,
        output Mem_RData, Mem_Ack,
        input  IF_Ready, IF_RData,
        input  MEM_Ready, MEM_RData,
        input  Bus_Err,
        input  Mem_En, Mem_We, Mem_Addr, Mem_WData,
        input  Pipe_Stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between instruction fetch (IF) and the
// MEM-stage load/store path. MEM has fixed priority because it carries the
// older instruction. One access is outstanding at a time; the granted request
// is latched, the memory ack is awaited with a timeout, and read data is
// returned to the granted requester with a one-cycle Ready pulse.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - mem_port_arbiter_if.slave (requester, memory and status signals)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no access in flight; arbitrate MEM over IF
// BUSY_MEM | load/store on the memory port, waiting for Mem_Ack
// BUSY_IF  | fetch on the memory port, waiting for Mem_Ack
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_MEM = 2'd1,
        BUSY_IF  = 2'd2
    } ArbState;

    // Timeout fires on the edge where the counter would reach MAX_WAIT,
    // giving exactly MAX_WAIT busy cycles without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    ArbState    state;
    logic [7:0] waitCnt;
    logic       timedOut;
    logic       accessDone;
    logic       readyPending;

    assign timedOut     = (waitCnt == WAIT_LAST);
    assign accessDone   = bus.Mem_Ack | timedOut;
    // A requester still holds Req during its Ready cycle, so arbitration is
    // skipped in that cycle to avoid re-serving the same request.
    assign readyPending = bus.IF_Ready | bus.MEM_Ready;

    assign bus.Pipe_Stall = (bus.IF_Req & ~bus.IF_Ready) | (bus.MEM_Req & ~bus.MEM_Ready);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            waitCnt       <= 8'd0;
            bus.IF_Ready  <= 1'b0;
            bus.IF_RData  <= {DATA_W{1'b0}};
            bus.MEM_Ready <= 1'b0;
            bus.MEM_RData <= {DATA_W{1'b0}};
            bus.Bus_Err   <= 1'b0;
            bus.Mem_En    <= 1'b0;
            bus.Mem_We    <= 1'b0;
            bus.Mem_Addr  <= {ADDR_W{1'b0}};
            bus.Mem_WData <= {DATA_W{1'b0}};
        end else begin
            bus.IF_Ready  <= 1'b0;
            bus.IF_RData  <= {DATA_W{1'b0}};
            bus.MEM_Ready <= 1'b0;
            bus.MEM_RData <= {DATA_W{1'b0}};
            bus.Bus_Err   <= 1'b0;

            case (state)
                IDLE: begin
                    waitCnt <= 8'd0;
                    if (!readyPending) begin
                        if (bus.MEM_Req) begin
                            state         <= BUSY_MEM;
                            bus.Mem_En    <= 1'b1;
                            bus.Mem_We    <= bus.MEM_We;
                            bus.Mem_Addr  <= bus.MEM_Addr;
                            bus.Mem_WData <= bus.MEM_WData;
                        end else if (bus.IF_Req) begin
                            state         <= BUSY_IF;
                            bus.Mem_En    <= 1'b1;
                            bus.Mem_We    <= 1'b0;
                            bus.Mem_Addr  <= bus.IF_Addr;
                            bus.Mem_WData <= {DATA_W{1'b0}};
                        end
                    end
                end

                BUSY_MEM, BUSY_IF: begin
                    if (accessDone) begin
                        if (state == BUSY_MEM) begin
                            bus.MEM_Ready <= 1'b1;
                            // Stores and timed-out accesses return zero.
                            bus.MEM_RData <= (bus.Mem_Ack && !bus.Mem_We) ? bus.Mem_RData
                                                                          : {DATA_W{1'b0}};
                        end else begin
                            bus.IF_Ready <= 1'b1;
                            bus.IF_RData <= bus.Mem_Ack ? bus.Mem_RData : {DATA_W{1'b0}};
                        end
                        bus.Bus_Err   <= ~bus.Mem_Ack;
                        state         <= IDLE;
                        waitCnt       <= 8'd0;
                        bus.Mem_En    <= 1'b0;
                        bus.Mem_We    <= 1'b0;
                        bus.Mem_Addr  <= {ADDR_W{1'b0}};
                        bus.Mem_WData <= {DATA_W{1'b0}};
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    waitCnt       <= 8'd0;
                    bus.Mem_En    <= 1'b0;
                    bus.Mem_We    <= 1'b0;
                    bus.Mem_Addr  <= {ADDR_W{1'b0}};
                    bus.Mem_WData <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

endmodule
